e_md_ctrl: RTL and testbench

- Execute-stage multiply/divide sequencer for the 5-stage MIPS pipeline.
- Accepts MDU ops decoded from the decode-stage opcode/func fields, latches operands, and holds the unit busy for a fixed multi-cycle latency.
- Commits results to the HI/LO registers and raises the decode-stage stall whenever a younger MDU instruction must wait.
- Owns HI/LO; mfhi/mflo read data comes from here.

---
 rtl/e_md_ctrl_pkg.sv | 50 +++++
 rtl/e_md_ctrl_md_arith.sv | 60 ++++++
 rtl/e_md_ctrl.sv | 111 +++++++++++
 tb/tb_e_md_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e_md_ctrl_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// MDU op encodings, default latencies and the decoder opcode/func constants.
package e_md_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // SPECIAL-opcode func codes the D-stage controller maps onto md_op_e
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI     = 6'h10;
  localparam logic [5:0] FN_MTHI     = 6'h11;
  localparam logic [5:0] FN_MFLO     = 6'h12;
  localparam logic [5:0] FN_MTLO     = 6'h13;
  localparam logic [5:0] FN_MULT     = 6'h18;
  localparam logic [5:0] FN_MULTU    = 6'h19;
  localparam logic [5:0] FN_DIV      = 6'h1A;
  localparam logic [5:0] FN_DIVU     = 6'h1B;

  function automatic md_op_e md_decode(input logic [3:0] raw);
    case (raw)
      4'd1:    return MD_MULT;
      4'd2:    return MD_MULTU;
      4'd3:    return MD_DIV;
      4'd4:    return MD_DIVU;
      4'd5:    return MD_MFHI;
      4'd6:    return MD_MFLO;
      4'd7:    return MD_MTHI;
      4'd8:    return MD_MTLO;
      default: return MD_NONE;
    endcase
  endfunction

  function automatic logic md_is_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_ctrl_md_arith.sv
// Combinational 64-bit result generator: signed/unsigned multiply and divide.
// Result layout is {HI, LO}; divide by zero is flagged so the commit can be skipped.
module md_arith
  import e_md_ctrl_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_result,
  output logic        o_div_zero
);

  logic [63:0]        w_rs_sx;
  logic [63:0]        w_rt_sx;
  logic [63:0]        w_smul;
  logic [63:0]        w_umul;
  logic               w_rt_zero;
  logic [31:0]        w_divisor;
  logic signed [31:0] w_rs_sg;
  logic signed [31:0] w_dv_sg;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product
  assign w_rs_sx = {{32{i_rs[31]}}, i_rs};
  assign w_rt_sx = {{32{i_rt[31]}}, i_rt};
  assign w_smul  = w_rs_sx * w_rt_sx;
  assign w_umul  = {32'd0, i_rs} * {32'd0, i_rt};

  // A zero divisor is replaced so the dividers never see an undefined operand
  assign w_rt_zero = (i_rt == 32'd0);
  assign w_divisor = w_rt_zero ? 32'd1 : i_rt;
  assign w_rs_sg   = i_rs;
  assign w_dv_sg   = w_divisor;
  assign w_squot   = w_rs_sg / w_dv_sg;
  assign w_srem    = w_rs_sg % w_dv_sg;
  assign w_uquot   = i_rs / w_divisor;
  assign w_urem    = i_rs % w_divisor;

  always_comb begin
    o_result   = 64'd0;
    o_div_zero = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_smul;
      MD_MULTU: o_result = w_umul;
      MD_DIV: begin
        o_result   = {w_srem, w_squot};
        o_div_zero = w_rt_zero;
      end
      MD_DIVU: begin
        o_result   = {w_urem, w_uquot};
        o_div_zero = w_rt_zero;
      end
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_md_ctrl.sv
// Execute-stage multiply/divide sequencer: latches the result at start, holds the
// unit busy for a fixed latency, then commits to HI/LO. Owns HI/LO and the MDU stall.
module e_md_ctrl
  import e_md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        D_md_use,
  output logic        E_start,
  output logic        E_busy,
  output logic        D_stall_md,
  output logic [31:0] E_md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_op_e             w_op;
  logic               w_start;
  logic               w_commit;
  logic [CNT_W-1:0]   w_cnt_load;
  logic [63:0]        w_result;
  logic               w_div_zero;

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_pend;
  logic               r_pend_dz;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  assign w_op     = md_decode(E_md_op);
  assign w_start  = md_is_start(w_op) & ~r_busy;
  assign w_commit = r_busy & (r_cnt == CNT_W'(1));

  md_arith u_md_arith (
    .i_op       (w_op),
    .i_rs       (E_rs_val),
    .i_rt       (E_rt_val),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  always_comb begin
    w_cnt_load = CNT_W'(MULT_CYCLES);
    if ((w_op == MD_DIV) || (w_op == MD_DIVU)) begin
      w_cnt_load = CNT_W'(DIV_CYCLES);
    end else begin
      w_cnt_load = CNT_W'(MULT_CYCLES);
    end
  end

  // Busy window: load on start, count down, drop busy on the 1->0 step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_pend    <= 64'd0;
      r_pend_dz <= 1'b0;
    end else if (w_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= w_cnt_load;
      r_pend    <= w_result;
      r_pend_dz <= w_div_zero;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_commit) begin
        r_busy <= 1'b0;
      end
    end
  end

  // HI/LO: multi-cycle commit, or single-cycle MTHI/MTLO while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_pend_dz) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else if (!r_busy && (w_op == MD_MTHI)) begin
      r_hi <= E_rs_val;
    end else if (!r_busy && (w_op == MD_MTLO)) begin
      r_lo <= E_rs_val;
    end
  end

  always_comb begin
    E_md_out = 32'd0;
    case (w_op)
      MD_MFHI: E_md_out = r_hi;
      MD_MFLO: E_md_out = r_lo;
      default: E_md_out = 32'd0;
    endcase
  end

  assign E_start    = w_start;
  assign E_busy     = r_busy;
  assign D_stall_md = D_md_use & (w_start | r_busy);
  assign HI         = r_hi;
  assign LO         = r_lo;

endmodule

// File: tb/tb_e_md_ctrl.sv
// Directed bench for e_md_ctrl: a cycle-indexed reference model checked every
// negedge, plus literal expectations taken straight from the arithmetic rules.
module tb_e_md_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic        D_md_use;
  logic        E_start;
  logic        E_busy;
  logic        D_stall_md;
  logic [31:0] E_md_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: absolute cycle numbers, commit cycle and pending result
  int          cyc         = 0;
  int          m_busy_last = -1;
  logic [31:0] m_hi        = 32'd0;
  logic [31:0] m_lo        = 32'd0;
  logic [31:0] m_pend_hi   = 32'd0;
  logic [31:0] m_pend_lo   = 32'd0;
  bit          m_pend_ok   = 1'b0;

  e_md_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .D_md_use   (D_md_use),
    .E_start    (E_start),
    .E_busy     (E_busy),
    .D_stall_md (D_stall_md),
    .E_md_out   (E_md_out),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic int op_norm(input logic [3:0] op);
    return (op <= 4'd8) ? int'(op) : 0;
  endfunction

  always @(posedge clk) begin
    int    o;
    int    sa;
    int    sb;
    longint sp;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    if (reset) begin
      o = op_norm(E_md_op);
      if (cyc <= m_busy_last) begin
        if (cyc == m_busy_last && m_pend_ok) begin
          m_hi = m_pend_hi;
          m_lo = m_pend_lo;
        end
      end else if (o >= 1 && o <= 4) begin
        sa = E_rs_val;
        sb = E_rt_val;
        ua = {32'd0, E_rs_val};
        ub = {32'd0, E_rt_val};
        m_pend_ok = 1'b1;
        if (o == 1) begin
          sp = longint'(sa) * longint'(sb);
          {m_pend_hi, m_pend_lo} = sp;
        end else if (o == 2) begin
          up = ua * ub;
          {m_pend_hi, m_pend_lo} = up;
        end else if (sb == 0) begin
          m_pend_ok = 1'b0;
        end else if (o == 3) begin
          m_pend_lo = sa / sb;
          m_pend_hi = sa % sb;
        end else begin
          m_pend_lo = E_rs_val / E_rt_val;
          m_pend_hi = E_rs_val % E_rt_val;
        end
        m_busy_last = cyc + ((o <= 2) ? 5 : 10);
      end else if (o == 7) begin
        m_hi = E_rs_val;
      end else if (o == 8) begin
        m_lo = E_rs_val;
      end
    end
    cyc++;
  end

  always @(negedge reset) begin
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    m_busy_last = -1;
    m_pend_ok   = 1'b0;
  end

  // Compare process: every output against the model, every cycle out of reset
  always @(negedge clk) begin
    bit e_busy;
    bit e_start;
    int o;
    logic [31:0] e_out;
    if (chk_en && reset) begin
      o       = op_norm(E_md_op);
      e_busy  = (cyc <= m_busy_last);
      e_start = (o >= 1 && o <= 4) && !e_busy;
      e_out   = (o == 5) ? m_hi : ((o == 6) ? m_lo : 32'd0);
      chk("E_busy",     {31'd0, E_busy},     {31'd0, e_busy});
      chk("E_start",    {31'd0, E_start},    {31'd0, e_start});
      chk("D_stall_md", {31'd0, D_stall_md}, {31'd0, D_md_use & (e_start | e_busy)});
      chk("E_md_out",   E_md_out, e_out);
      chk("HI",         HI, m_hi);
      chk("LO",         LO, m_lo);
    end
  end

  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic duse);
    E_md_op  = op;
    E_rs_val = rs;
    E_rt_val = rt;
    D_md_use = duse;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic duse);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, duse);
  endtask

  task automatic peek(input logic [3:0] op, input string name, input logic [31:0] exp);
    E_md_op = op;
    #1;
    chk(name, E_md_out, exp);
  endtask

  initial begin
    reset    = 1'b0;
    E_md_op  = 4'd0;
    E_rs_val = 32'd0;
    E_rt_val = 32'd0;
    D_md_use = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    chk("lit_reset_HI", HI, 32'd0);
    chk("lit_reset_busy", {31'd0, E_busy}, 32'd0);

    // MULT -2*3 with MFLO waiting in D
    step(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    chk("lit_mult_busy_t1", {31'd0, E_busy}, 32'd1);
    idle(5, 1'b1);
    chk("lit_mult_HI", HI, 32'hFFFFFFFF);
    chk("lit_mult_LO", LO, 32'hFFFFFFFA);
    chk("lit_mult_busy_t6", {31'd0, E_busy}, 32'd0);
    peek(4'd6, "lit_mflo_out", 32'hFFFFFFFA);
    step(4'd6, 32'd0, 32'd0, 1'b0);

    // MULTU same operands; non-MDU op in D while busy
    step(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    D_md_use = 1'b0;
    #1;
    chk("lit_add_no_stall", {31'd0, D_stall_md}, 32'd0);
    idle(5, 1'b0);
    chk("lit_multu_HI", HI, 32'h00000002);
    chk("lit_multu_LO", LO, 32'hFFFFFFFA);

    // DIV -7/2, MFHI while busy sees the old value
    step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    peek(4'd5, "lit_mfhi_busy_old", 32'h00000002);
    idle(10, 1'b0);
    chk("lit_div_LO", LO, 32'hFFFFFFFD);
    chk("lit_div_HI", HI, 32'hFFFFFFFF);

    // MTHI idle; DIVU 7/0 with MTLO and MULT injected while busy
    step(4'd7, 32'h12345678, 32'd0, 1'b0);
    chk("lit_mthi_HI", HI, 32'h12345678);
    chk("lit_mthi_busy", {31'd0, E_busy}, 32'd0);
    step(4'd4, 32'd7, 32'd0, 1'b0);
    step(4'd8, 32'hDEADBEEF, 32'd0, 1'b0);
    step(4'd1, 32'd9, 32'd9, 1'b1);
    step(4'd12, 32'd0, 32'd0, 1'b0);
    idle(7, 1'b0);
    chk("lit_divu0_HI", HI, 32'h12345678);
    chk("lit_divu0_LO", LO, 32'hFFFFFFFD);
    chk("lit_divu0_busy", {31'd0, E_busy}, 32'd0);

    // Back-to-back: MULT 5*6 at t, DIV 100/7 at t+6
    step(4'd1, 32'd5, 32'd6, 1'b0);
    idle(5, 1'b0);
    chk("lit_b2b_first_LO", LO, 32'd30);
    step(4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("lit_b2b_window", {31'd0, E_busy}, 32'd1);
      step(4'd0, 32'd0, 32'd0, 1'b0);
    end
    chk("lit_b2b_end_busy", {31'd0, E_busy}, 32'd0);
    chk("lit_b2b_LO", LO, 32'd14);
    chk("lit_b2b_HI", HI, 32'd2);

    // Asynchronous reset in the middle of a DIV
    step(4'd3, 32'd50, 32'd3, 1'b0);
    idle(3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("lit_rst_HI", HI, 32'd0);
    chk("lit_rst_LO", LO, 32'd0);
    chk("lit_rst_busy", {31'd0, E_busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    peek(4'd5, "lit_rst_mfhi", 32'd0);
    step(4'd5, 32'd0, 32'd0, 1'b0);
    idle(12, 1'b0);
    chk("lit_rst_no_commit_LO", LO, 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
